tinyalu_responder: RTL and testbench
====================================

// Module: tinyalu_responder
// PURPOSE
//  - DUT-side responder for the TinyALU start/done protocol.
//  - Samples op/A/B when start is high and executes the operation.
//  - Returns the result with a one-cycle done pulse.
//  - Single-cycle path for add/and/xor; pipelined multiplier of MUL_LATENCY stages.
//  - The existing tinyalu testbench (tpgen/scoreboard/coverage) drives and checks it unchanged.
// PARAMETERS
//  DATA_W       8   operand width; result is 2*DATA_W
//  MUL_LATENCY  3   edges from first sampled start to done for mul_op; legal range 2..8
// PORTS
//  clk      in   1         sole clock, rising edge
//  reset_n  in   1         synchronous, active-low reset
//  start    in   1         request; held high with op/A/B stable until done
//  op       in   3         operation_t: no_op 000, add 001, and 010, xor 011, mul 100, rst 111
//  A        in   DATA_W    operand A
//  B        in   DATA_W    operand B
//  done     out  1         one-cycle pulse; result valid in the same cycle
//  result   out  2*DATA_W  registered result, held until next done or reset
//  err      out  1         sticky protocol-error flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): done=0, result=0, err=0, FSM=IDLE, mul pipe valid bits cleared.
//  - FSM states IDLE, MUL_BUSY, WAIT_LOW.
//  - IDLE, start=1 sampled: action depends on op.
//    - add/and/xor: result and done=1 registered at that edge (latency 1); go to WAIT_LOW.
//    - mul: load pipe; go to MUL_BUSY.
//    - no_op: no done, stay IDLE.
//    - rst_op: same clearing as reset_n=0; stay IDLE.
//    - 101/110 (illegal): done=1, result=0; go to WAIT_LOW.
//  - MUL_BUSY: done=1 with result=A*B at edge MUL_LATENCY-1 after entry, i.e. MUL_LATENCY edges from first sample; go to WAIT_LOW.
//  - MUL_BUSY, start sampled 0: abort, flush pipe, no done, go to IDLE.
//  - WAIT_LOW: done returns 0 next edge; ignore start until sampled 0, then IDLE.
//    - Prevents re-execution when the tester holds start one extra cycle.
//  - Arithmetic:
//    - add: zero-extended DATA_W+1 sum.
//    - and/xor: bitwise result, zero-extended.
//    - mul: full unsigned 2*DATA_W product, no truncation.
//  - done is never high two consecutive cycles; result changes only with done=1, rst_op or reset.
//  - reset_n=0 mid-mul: op discarded, no late done after reset release.
//  - reset_n=0 and start=1 at the same edge: reset wins.
// CONFIGURATION
//  - Macro TINYALU_PROTOCOL_CHECK_EN.
//  - Defined: err set (sticky until reset/rst_op) when either condition holds.
//    - op, A or B changes while start=1 in MUL_BUSY.
//    - Illegal opcode 101/110 is sampled.
//  - Not defined: err tied 0; no checking logic synthesised.
//  - Functional behaviour is otherwise identical in both builds.
// STRUCTURE
//  - Shared package tinyalu_pkg:
//    - operation_t enum (no_op, add_op, and_op, xor_op, mul_op, rst_op).
//    - responder state enum.
//    - constant MUL_LATENCY_DEFAULT=3.
//  - Sub-module tinyalu_mul_pipe.
//    - Parameters DATA_W, MUL_LATENCY.
//    - Ports: in_valid, flush, a, b; out_valid, product.
//    - Product and valid bit shift through MUL_LATENCY-1 register stages.
//  - Top holds the FSM, the single-cycle ALU, and the result/done/err registers.
// TESTING
//  1 Reset: reset_n=0 for 2 cycles, start=1 -> done=0, result=0, err=0 after the first edge.
//  2 Add: start, add_op, A=FF, B=FF -> done=1 one edge later, result=16'h01FE.
//    - start held 1 extra cycle -> no second done.
//  3 Mul: start, mul_op, A=FF, B=FF -> done=1 exactly 3 edges after first sample, result=16'hFE01.
//    - done low in the 2 prior cycles.
//  4 Mid-op resets:
//    - Mul abort: mul_op A=05 B=07, reset_n=0 at edge 2 -> no done, result=0.
//    - rst_op: start=1 with op=111 -> result cleared, no done.
//  5 Back-to-back: and(F0,3C) -> result=0030, start low 1 cycle, xor(F0,3C) -> result=00CC.
//    - Exactly two done pulses.
//  6 Checks, macro defined: op 110 -> done, result=0, err=1; B changed mid-mul -> err=1.
//    - Macro undefined: err stays 0.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// Shared types and constants for the TinyALU responder.
// Optional checking is enabled by TINYALU_PROTOCOL_CHECK_EN, which lives in tinyalu_responder.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    WAIT_LOW = 2'd2
  } responder_state_t;

  localparam int MUL_LATENCY_DEFAULT = 3;

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// Unsigned multiplier whose product and valid bit travel through MUL_LATENCY-1 register stages.
// The responder's result register adds the final edge, giving MUL_LATENCY edges in total.
module tinyalu_mul_pipe #(
  parameter int DATA_W      = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   product
);

  localparam int STAGES = MUL_LATENCY - 1;
  localparam int PW     = 2 * DATA_W;

  logic [PW-1:0]     prod_q [STAGES];
  logic [STAGES-1:0] vld_q;

  // Product data needs no reset; only the valid bits decide whether it is used.
  always_ff @(posedge clk) begin
    prod_q[0] <= PW'(a) * PW'(b);
    for (int i = 1; i < STAGES; i++) begin
      prod_q[i] <= prod_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign product   = prod_q[STAGES-1];

endmodule

// File: rtl/tinyalu_responder.sv
// DUT-side responder for the TinyALU start/done protocol: single-cycle add/and/xor, pipelined mul.
// Define TINYALU_PROTOCOL_CHECK_EN to build the sticky err flag; otherwise err is tied low.
module tinyalu_responder
  import tinyalu_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_W-1:0]     A,
  input  logic [DATA_W-1:0]     B,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result,
  output logic                  err
);

  localparam int RW = 2 * DATA_W;

  responder_state_t state_q, state_d;
  logic             done_q, done_d;
  logic [RW-1:0]    result_q, result_d;
  logic [RW-1:0]    aluResult;
  logic [RW-1:0]    mulProduct;
  logic             mulLoad, mulFlush, mulValid;
  logic             rstOp;

  always_comb begin
    aluResult = '0;
    case (op)
      add_op:  aluResult = RW'(A) + RW'(B);
      and_op:  aluResult = RW'(A & B);
      xor_op:  aluResult = RW'(A ^ B);
      default: aluResult = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    result_d = result_q;
    mulLoad  = 1'b0;
    mulFlush = 1'b0;
    rstOp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            no_op: state_d = IDLE;
            rst_op: begin
              rstOp    = 1'b1;
              mulFlush = 1'b1;
              result_d = '0;
            end
            mul_op: begin
              mulLoad = 1'b1;
              state_d = MUL_BUSY;
            end
            add_op, and_op, xor_op: begin
              done_d   = 1'b1;
              result_d = aluResult;
              state_d  = WAIT_LOW;
            end
            // Illegal opcodes still complete the handshake with a zero result.
            default: begin
              done_d   = 1'b1;
              result_d = '0;
              state_d  = WAIT_LOW;
            end
          endcase
        end
      end
      MUL_BUSY: begin
        if (!start) begin
          mulFlush = 1'b1;
          state_d  = IDLE;
        end else if (mulValid) begin
          done_d   = 1'b1;
          result_d = mulProduct;
          state_d  = WAIT_LOW;
        end
      end
      // Holding here until start drops stops a lingering start from re-executing.
      WAIT_LOW: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  tinyalu_mul_pipe #(
    .DATA_W      (DATA_W),
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (mulLoad),
    .flush     (mulFlush),
    .a         (A),
    .b         (B),
    .out_valid (mulValid),
    .product   (mulProduct)
  );

  assign done   = done_q;
  assign result = result_q;

`ifdef TINYALU_PROTOCOL_CHECK_EN
  logic              err_q, err_d;
  logic [2:0]        opCap_q;
  logic [DATA_W-1:0] aCap_q, bCap_q;
  logic              illegalOp, operandChange;

  assign illegalOp     = (state_q == IDLE) && start && ((op == 3'b101) || (op == 3'b110));
  assign operandChange = (state_q == MUL_BUSY) && start &&
                         ((op != opCap_q) || (A != aCap_q) || (B != bCap_q));

  always_comb begin
    err_d = err_q;
    if (rstOp) begin
      err_d = 1'b0;
    end else if (illegalOp || operandChange) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q   <= 1'b0;
      opCap_q <= '0;
      aCap_q  <= '0;
      bCap_q  <= '0;
    end else begin
      err_q <= err_d;
      if (mulLoad) begin
        opCap_q <= op;
        aCap_q  <= A;
        bCap_q  <= B;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tinyalu_responder.sv
// Randomised self-checking bench for tinyalu_responder against a behavioural TinyALU model.
// Follows TINYALU_PROTOCOL_CHECK_EN to decide whether err is expected to rise.
module tb_tinyalu_responder;

  localparam int DATA_W      = 8;
  localparam int MUL_LATENCY = 3;
  localparam int RW          = 2 * DATA_W;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_BAD = 3'b110;
  localparam logic [2:0] OP_RST = 3'b111;

`ifdef TINYALU_PROTOCOL_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              done;
  logic [RW-1:0]     result;
  logic              err;

  int checks    = 0;
  int failures  = 0;
  int doneCount = 0;
  logic prevDone = 1'b0;

  tinyalu_responder #(
    .DATA_W      (DATA_W),
    .MUL_LATENCY (MUL_LATENCY)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Count done pulses and flag any two in a row.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      doneCount++;
      checks++;
      if (prevDone) begin
        failures++;
        $display("[TB] FAIL done_consecutive actual=two_cycles required=one_cycle at %0t", $time);
      end
    end
    prevDone = (done === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural TinyALU arithmetic.
  function automatic logic [RW-1:0] model(input logic [2:0] o, input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    int unsigned x, y;
    x = a;
    y = b;
    case (o)
      OP_ADD:  return RW'(x + y);
      OP_AND:  return RW'(x & y);
      OP_XOR:  return RW'(x ^ y);
      OP_MUL:  return RW'(x * y);
      default: return '0;
    endcase
  endfunction

  function automatic int modelLatency(input logic [2:0] o);
    return (o == OP_MUL) ? MUL_LATENCY : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start and wait (bounded) for the first done; start is left high.
  task automatic run_op(input logic [2:0] o, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        output int edges, output logic [RW-1:0] res);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    edges = 0;
    res   = 'x;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (done === 1'b1) begin
        edges = i;
        res   = result;
        break;
      end
    end
  endtask

  task automatic release_start();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b1;
    op      = OP_ADD;
    A       = 8'hFF;
    B       = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done actual=%0b required=0", done); end
      checks++;
      if (result !== '0) begin failures++; $display("[TB] FAIL reset_result actual=%h required=0000", result); end
      checks++;
      if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err actual=%0b required=0", err); end
    end
    start   = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    int edges;
    logic [RW-1:0] res;
    run_op(OP_ADD, 8'hFF, 8'hFF, edges, res);
    checks++;
    if (edges != 1) begin failures++; $display("[TB] FAIL add_latency actual=%0d required=1", edges); end
    checks++;
    if (res !== 16'h01FE) begin failures++; $display("[TB] FAIL add_result actual=%h required=01FE", res); end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL add_held_start_done actual=%0b required=0", done); end
    checks++;
    if (result !== 16'h01FE) begin failures++; $display("[TB] FAIL add_result_hold actual=%h required=01FE", result); end
    release_start();
  endtask

  task automatic test_mul();
    int edges;
    logic [RW-1:0] res;
    run_op(OP_MUL, 8'hFF, 8'hFF, edges, res);
    checks++;
    if (edges != MUL_LATENCY) begin
      failures++; $display("[TB] FAIL mul_latency actual=%0d required=%0d", edges, MUL_LATENCY);
    end
    checks++;
    if (res !== 16'hFE01) begin failures++; $display("[TB] FAIL mul_result actual=%h required=FE01", res); end
    release_start();
  endtask

  task automatic test_mid_op_resets();
    int edges;
    logic [RW-1:0] res;
    bit sawDone;
    start = 1'b1; op = OP_MUL; A = 8'h05; B = 8'h07;
    tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || result !== '0) begin
      failures++; $display("[TB] FAIL mul_abort_reset actual=done%0b/%h required=done0/0000", done, result);
    end
    reset_n = 1'b1;
    start   = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) sawDone = 1'b1;
    end
    checks++;
    if (sawDone) begin failures++; $display("[TB] FAIL mul_abort_late_done actual=1 required=0"); end

    run_op(OP_ADD, 8'h10, 8'h20, edges, res);
    checks++;
    if (res !== 16'h0030) begin failures++; $display("[TB] FAIL pre_rstop_result actual=%h required=0030", res); end
    release_start();
    start = 1'b1; op = OP_RST;
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL rstop_done actual=%0b required=0", done); end
    checks++;
    if (result !== '0) begin failures++; $display("[TB] FAIL rstop_result actual=%h required=0000", result); end
    release_start();
  endtask

  task automatic test_back_to_back();
    int edges;
    int startCount;
    logic [RW-1:0] res;
    startCount = doneCount;
    run_op(OP_AND, 8'hF0, 8'h3C, edges, res);
    checks++;
    if (res !== 16'h0030) begin failures++; $display("[TB] FAIL b2b_and actual=%h required=0030", res); end
    release_start();
    run_op(OP_XOR, 8'hF0, 8'h3C, edges, res);
    checks++;
    if (res !== 16'h00CC || edges != 1) begin
      failures++; $display("[TB] FAIL b2b_xor actual=%h/lat%0d required=00CC/lat1", res, edges);
    end
    release_start();
    tick();
    checks++;
    if (doneCount - startCount != 2) begin
      failures++; $display("[TB] FAIL b2b_done_pulses actual=%0d required=2", doneCount - startCount);
    end
  endtask

  task automatic test_protocol_check();
    int edges;
    logic [RW-1:0] res;
    run_op(OP_BAD, 8'($urandom), 8'($urandom), edges, res);
    checks++;
    if (edges != 1 || res !== '0) begin
      failures++; $display("[TB] FAIL illegal_op actual=lat%0d/%h required=lat1/0000", edges, res);
    end
    checks++;
    if (err !== CHECK_EN) begin failures++; $display("[TB] FAIL illegal_err actual=%0b required=%0b", err, CHECK_EN); end
    release_start();
    start = 1'b1; op = OP_RST;
    tick();
    checks++;
    if (err !== 1'b0) begin failures++; $display("[TB] FAIL rstop_err_clear actual=%0b required=0", err); end
    release_start();

    start = 1'b1; op = OP_MUL; A = 8'h05; B = 8'h07;
    tick();
    checks++;
    if (err !== 1'b0) begin failures++; $display("[TB] FAIL mul_stable_err actual=%0b required=0", err); end
    B = 8'h08;
    tick();
    checks++;
    if (err !== CHECK_EN) begin failures++; $display("[TB] FAIL mul_change_err actual=%0b required=%0b", err, CHECK_EN); end
    for (int i = 0; i < MUL_LATENCY; i++) tick();
    release_start();
    start = 1'b1; op = OP_RST;
    tick();
    release_start();
  endtask

  task automatic test_random();
    int edges;
    int kind;
    logic [RW-1:0] res;
    logic [RW-1:0] expected;
    logic [2:0] o;
    logic [DATA_W-1:0] a, b;
    bit sawDone;
    expected = result;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      a    = 8'($urandom);
      b    = 8'($urandom);
      o    = (kind == 0) ? OP_NOP : (kind == 1) ? OP_ADD : (kind == 2) ? OP_AND :
             (kind == 3) ? OP_XOR : OP_MUL;
      if (o == OP_NOP) begin
        start = 1'b1; op = o; A = a; B = b;
        sawDone = 1'b0;
        for (int i = 0; i < 3; i++) begin
          tick();
          if (done === 1'b1) sawDone = 1'b1;
        end
        checks++;
        if (sawDone || result !== expected) begin
          failures++; $display("[TB] FAIL rand_nop actual=done%0b/%h required=done0/%h", sawDone, result, expected);
        end
      end else begin
        run_op(o, a, b, edges, res);
        expected = model(o, a, b);
        checks++;
        if (edges != modelLatency(o) || res !== expected) begin
          failures++;
          $display("[TB] FAIL rand_op op=%b a=%h b=%h actual=lat%0d/%h required=lat%0d/%h",
                   o, a, b, edges, res, modelLatency(o), expected);
        end
        if ($urandom_range(0, 1) == 1) begin
          tick();
          checks++;
          if (done !== 1'b0) begin failures++; $display("[TB] FAIL rand_held_done actual=%0b required=0", done); end
        end
      end
      release_start();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = OP_NOP;
    A       = '0;
    B       = '0;
    test_reset();
    test_add();
    test_mul();
    test_mid_op_resets();
    test_back_to_back();
    test_protocol_check();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
